uart_byte_tx: RTL and testbench

Byte-wide UART transmitter. It serialises one 8-bit word per valid/ready handshake onto `FPGA_TX` as 8N1 (optionally 8E1), LSB first, at a fixed baud set by a clock divider parameter. It is the transmit-side partner of the board's UART receive path: reading results produced by the tarot logic are handed to it byte by byte for the host link.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_byte_tx.sv | 102 ++++++++++
 tb/tb_uart_byte_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-cycle tick every CLKS_PER_BIT cycles, synchronous restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Counts down so the tick is a simple zero compare; restart reloads the full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || count == '0) begin
      count <= LAST;
    end else begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide 8N1 UART transmitter with valid/ready input; define UART_TX_PARITY_EN for 8E1.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       FPGA_TX,
  output logic       tx_done
);

  tx_state_t  state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] data, data_n;
  logic       line_n;
  logic       restart;
  logic       tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  assign tx_done  = (state == STOP) && tick;
  assign tx_ready = (state == IDLE) || tx_done;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    data_n    = data;
    restart   = 1'b0;
    line_n    = 1'b1;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n = START;
          data_n  = tx_data;
          restart = 1'b1;
        end
      end
      START: begin
        line_n = 1'b0;
        if (tick) state_n = DATA;
      end
      DATA: begin
        line_n = data[bit_cnt];
        if (tick) begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_n = ^data;
        if (tick) state_n = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          // A handshake in the final stop cycle chains straight into the next start bit.
          if (tx_valid) begin
            state_n = START;
            data_n  = tx_data;
            restart = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      data    <= '0;
      FPGA_TX <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      data    <= data_n;
      FPGA_TX <= line_n;
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: directed scenarios plus random bytes against a frame model.
module tb_uart_byte_tx;

  localparam int unsigned CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       FPGA_TX;
  logic       tx_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_byte_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .FPGA_TX (FPGA_TX),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Entered #1 after a rising edge with the DUT ready; the next edge is the handshake.
  task automatic tx_frame(input logic [7:0] d, input logic keep_valid,
                          input logic [7:0] d_next, input logic scramble);
    logic        fb[$];
    int unsigned ones;
    int unsigned len;
    ones = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      fb.push_back(d[i]);
      if (d[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    fb.push_back((ones % 2) == 1);
`endif
    fb.push_back(1'b1);
    len = fb.size() * CPB;
    check("ready_before_send", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = d;
    for (int unsigned k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        if (!keep_valid) tx_valid = 1'b0;
        if (scramble) tx_data = ~d;
        check("line_at_handshake", FPGA_TX, 1'b1);
      end else begin
        check("line_bit", FPGA_TX, fb[(k - 1) / CPB]);
      end
      check("done_pulse", tx_done, k == len - 1);
      check("ready_in_frame", tx_ready, k == len - 1);
      if (k == len - 1 && keep_valid) tx_data = d_next;
    end
  endtask

  task automatic idle_gap(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_line", FPGA_TX, 1'b1);
      check("idle_done", tx_done, 1'b0);
      check("idle_ready", tx_ready, 1'b1);
    end
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    logic       kv;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset
    #12;
    check("reset_line", FPGA_TX, 1'b1);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_done", tx_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      check("quiet_line", FPGA_TX, 1'b1);
      check("quiet_done", tx_done, 1'b0);
      @(posedge clk);
      #1;
    end
    check("quiet_ready", tx_ready, 1'b1);

    // Single byte
    tx_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    idle_gap(3);

    // Back-to-back
    tx_frame(8'h00, 1'b1, 8'hFF, 1'b0);
    tx_frame(8'hFF, 1'b0, 8'h00, 1'b0);
    idle_gap(2);

    // Data stability
    tx_frame(8'h3C, 1'b0, 8'h00, 1'b1);
    idle_gap(2);

    // Mid-frame reset during data bit 3 (line low there for 0x00)
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_reset_bit3", FPGA_TX, 1'b0);
    check("pre_reset_ready", tx_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset_line", FPGA_TX, 1'b1);
    check("async_reset_ready", tx_ready, 1'b1);
    check("async_reset_done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_gap(5);
    tx_frame(8'h55, 1'b0, 8'h00, 1'b0);
    idle_gap(2);

`ifdef UART_TX_PARITY_EN
    tx_frame(8'h07, 1'b0, 8'h00, 1'b0);
    idle_gap(2);
    tx_frame(8'h03, 1'b0, 8'h00, 1'b0);
    idle_gap(2);
`endif

    // Random bytes, randomly chained back-to-back
    cur = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      nxt = 8'($urandom);
      kv  = (i < 7) && ($urandom_range(0, 1) == 1);
      tx_frame(cur, kv, nxt, 1'b0);
      if (!kv) idle_gap($urandom_range(1, 4));
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
